ro_counter_ctrl: RTL and testbench

- Upstream neighbour of the RO PUF controller. Runs one ring-oscillator race per signature bit and produces the 2-bit counter_ctrl_state that the controller polls.
- While roen is high it clears two edge counters, counts edges from the selected RO pair, decides the response bit, then reports DONE.
- After each race it advances the RO-pair select used by the external RO mux.

---
 rtl/ro_puf_pkg.sv | 18 +
 rtl/ro_counter_ctrl_if.sv | 22 ++
 rtl/ro_edge_sync.sv | 27 ++
 rtl/ro_counter_ctrl.sv | 109 ++++++++++
 tb/tb_ro_counter_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared state encodings and sizing for the RO PUF blocks
package ro_puf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CLEAR = 2'b01;
  localparam logic [1:0] ST_COUNT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam int SIG_BITS = 128;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_COUNT = ST_COUNT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/ro_counter_ctrl_if.sv
// rtl/ro_counter_ctrl_if.sv - race control and result signals of the RO counter block
interface ro_counter_ctrl_if #(
  parameter int SEL_W = 7
);
  logic             roen;
  logic             ro_a;
  logic             ro_b;
  logic [1:0]       counter_ctrl_state;
  logic             puf_bit;
  logic [SEL_W-1:0] ro_sel;
  logic             timeout;

  modport master (
    output roen, ro_a, ro_b,
    input  counter_ctrl_state, puf_bit, ro_sel, timeout
  );

  modport slave (
    input  roen, ro_a, ro_b,
    output counter_ctrl_state, puf_bit, ro_sel, timeout
  );
endinterface

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - 2-flop synchroniser with registered rising-edge pulse
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic pulse
);

  logic s1, s2, prev;

  // prev always tracks s2, so clr only needs to squash a pulse already in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      prev  <= s2;
      pulse <= clr ? 1'b0 : (s2 & ~prev);
    end
  end

endmodule

// File: rtl/ro_counter_ctrl.sv
// rtl/ro_counter_ctrl.sv - one ring-oscillator race per signature bit, reports state to the PUF controller
module ro_counter_ctrl
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int WIN_W = 20,
  parameter int SEL_W = $clog2(SIG_BITS)
) (
  input  logic               clk,
  input  logic               rst,
  ro_counter_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic [WIN_W-1:0] win, win_nxt;
  logic             pulse_a, pulse_b, clr;
  logic             hit_a, hit_b, win_end;
  logic             latch_hit, latch_win, sel_adv;
  logic             puf_q, timeout_q;
  logic [SEL_W-1:0] sel_q;

  assign clr = (state_q == S_CLEAR);

  ro_edge_sync u_sync_a (.clk(clk), .rst(rst), .clr(clr), .din(bus.ro_a), .pulse(pulse_a));
  ro_edge_sync u_sync_b (.clk(clk), .rst(rst), .clr(clr), .din(bus.ro_b), .pulse(pulse_b));

  assign cnt_a_nxt = (pulse_a && cnt_a != CNT_MAX) ? cnt_a + CNT_W'(1) : cnt_a;
  assign cnt_b_nxt = (pulse_b && cnt_b != CNT_MAX) ? cnt_b + CNT_W'(1) : cnt_b;
  assign win_nxt   = win + WIN_W'(1);
  assign hit_a     = (cnt_a_nxt == CNT_MAX);
  assign hit_b     = (cnt_b_nxt == CNT_MAX);
  assign win_end   = (win_nxt == WIN_MAX);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_hit = 1'b0;
    latch_win = 1'b0;
    sel_adv   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.roen) state_d = S_CLEAR;
      S_CLEAR: state_d = S_COUNT;
      S_COUNT: begin
        if (!bus.roen) begin
          state_d = S_IDLE;
        end else if (hit_a || hit_b) begin
          state_d   = S_DONE;
          latch_hit = 1'b1;
        end else if (win_end) begin
          state_d   = S_DONE;
          latch_win = 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.roen) begin
          state_d = S_IDLE;
          sel_adv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The timeout decision uses the post-increment counts so a pulse landing on the last window cycle still counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_a     <= '0;
      cnt_b     <= '0;
      win       <= '0;
      puf_q     <= 1'b0;
      timeout_q <= 1'b0;
      sel_q     <= '0;
    end else begin
      if (state_q == S_CLEAR) begin
        cnt_a     <= '0;
        cnt_b     <= '0;
        win       <= '0;
        timeout_q <= 1'b0;
      end else if (state_q == S_COUNT) begin
        cnt_a <= cnt_a_nxt;
        cnt_b <= cnt_b_nxt;
        win   <= win_nxt;
      end
      if (latch_hit) begin
        puf_q     <= hit_a & ~hit_b;
        timeout_q <= 1'b0;
      end
      if (latch_win) begin
        puf_q     <= (cnt_a_nxt > cnt_b_nxt);
        timeout_q <= 1'b1;
      end
      if (sel_adv) sel_q <= sel_q + SEL_W'(1);
    end
  end

  assign bus.counter_ctrl_state = state_q;
  assign bus.puf_bit            = puf_q;
  assign bus.timeout            = timeout_q;
  assign bus.ro_sel             = sel_q;

endmodule

// File: tb/tb_ro_counter_ctrl.sv
// tb/tb_ro_counter_ctrl.sv - randomized race bench for ro_counter_ctrl with an edge-time reference model
module tb_ro_counter_ctrl;
  import ro_puf_pkg::*;

  localparam int CNT_W   = 4;
  localparam int WIN_W   = 7;
  localparam int SEL_W   = 7;
  localparam int TERM    = (1 << CNT_W) - 1;
  localparam int WIN_MAX = (1 << WIN_W) - 1;
  localparam int NEVER   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   sel_exp = 0;
  int   per_a = 0, per_b = 0, gen_s = 0;

  ro_counter_ctrl_if #(.SEL_W(SEL_W)) bus ();

  ro_counter_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Square wave sampled at edge e: first rising edge at gen_s, then every p cycles.
  function automatic logic wave(input int p, input int e);
    if (p == 0 || e < gen_s) return 1'b0;
    return ((e - gen_s) % p) < (p / 2);
  endfunction

  always @(negedge clk) begin
    bus.ro_a = wave(per_a, cyc + 1);
    bus.ro_b = wave(per_b, cyc + 1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Rising edges driven before edge e are counted at edge e+3.
  function automatic int hit_edge(input int p, input int s);
    if (p == 0) return NEVER;
    return s + (TERM - 1) * p + 3;
  endfunction

  function automatic int edges_by(input int p, input int s, input int t);
    if (p == 0 || t - 3 < s) return 0;
    return (t - 3 - s) / p + 1;
  endfunction

  task automatic quiet(input int n);
    per_a = 0;
    per_b = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_race(input int p_a, input int p_b, output int k0, output int s);
    @(negedge clk);
    k0    = cyc + 1;
    s     = k0 + 4;
    gen_s = s;
    per_a = p_a;
    per_b = p_b;
    bus.roen = 1'b1;
    @(negedge clk);
    chk("clear_state", bus.counter_ctrl_state, ST_CLEAR);
    @(negedge clk);
    chk("count_state", bus.counter_ctrl_state, ST_COUNT);
  endtask

  task automatic run_race(input int p_a, input int p_b, input int hold);
    int k0, s, ta, tb, tw, tdone, seen;
    logic exp_puf, exp_to;
    start_race(p_a, p_b, k0, s);
    tw = k0 + 1 + WIN_MAX;
    ta = hit_edge(p_a, s);
    tb = hit_edge(p_b, s);
    if (ta <= tw || tb <= tw) begin
      tdone   = (ta < tb) ? ta : tb;
      exp_puf = (ta < tb);
      exp_to  = 1'b0;
    end else begin
      tdone   = tw;
      exp_puf = edges_by(p_a, s, tw) > edges_by(p_b, s, tw);
      exp_to  = 1'b1;
    end
    seen = -1;
    for (int i = 0; i < WIN_MAX + 40; i++) begin
      if (bus.counter_ctrl_state == ST_DONE) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_edge", seen, tdone);
    chk("puf_bit", bus.puf_bit, exp_puf);
    chk("timeout", bus.timeout, exp_to);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", bus.counter_ctrl_state, ST_DONE);
      chk("puf_hold", bus.puf_bit, exp_puf);
    end
    bus.roen = 1'b0;
    @(negedge clk);
    chk("idle_after", bus.counter_ctrl_state, ST_IDLE);
    sel_exp = (sel_exp + 1) % SIG_BITS;
    chk("ro_sel", bus.ro_sel, sel_exp);
    quiet(5);
  endtask

  task automatic abort_race(input int p_a, input int p_b, input int n);
    int k0, s;
    start_race(p_a, p_b, k0, s);
    repeat (n) @(negedge clk);
    bus.roen = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.counter_ctrl_state, ST_IDLE);
    chk("abort_sel", bus.ro_sel, sel_exp);
    quiet(5);
  endtask

  function automatic int rand_period();
    int opts[6] = '{0, 4, 6, 8, 10, 12};
    return opts[$urandom_range(0, 5)];
  endfunction

  initial begin
    int k0, s;
    bus.roen = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_state", bus.counter_ctrl_state, ST_IDLE);
      chk("rst_sel", bus.ro_sel, 0);
      chk("rst_puf", bus.puf_bit, 0);
    end

    run_race(6, 10, 1);
    run_race(10, 6, 0);
    run_race(0, 0, 2);
    run_race(6, 6, 0);
    run_race(12, 0, 1);
    run_race(12, 12, 0);
    abort_race(4, 6, 10);
    run_race(8, 4, 0);

    start_race(6, 8, k0, s);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.roen = 1'b0;
    chk("midrst_state", bus.counter_ctrl_state, ST_IDLE);
    chk("midrst_sel", bus.ro_sel, 0);
    chk("midrst_puf", bus.puf_bit, 0);
    chk("midrst_to", bus.timeout, 0);
    sel_exp = 0;
    quiet(5);

    for (int r = 0; r < SIG_BITS; r++) begin
      if ($urandom_range(0, 7) == 0)
        abort_race(rand_period(), rand_period(), $urandom_range(1, 40));
      run_race(rand_period(), rand_period(), $urandom_range(0, 3));
    end
    chk("sel_wrap", bus.ro_sel, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
